chacha20_block: RTL and testbench

- Iterative ChaCha20 block function (RFC 8439 §2.3). Sits directly downstream of the quarter-round datapath: instantiates four QR units and drives them from a 16-word working-state register.
- Accepts key/nonce/counter via a valid/ready handshake, runs ROUNDS half-double-rounds (one column or diagonal round per cycle), adds the initial state, and presents a 512-bit keystream block via valid/ready.
- Feeds the downstream XOR/stream stage.

---
 rtl/chacha20_pkg.sv | 56 +++++
 rtl/chacha20_round_sel.sv | 34 +++
 rtl/chacha20_block.sv | 105 ++++++++++
 tb/tb_chacha20_block.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 types, constants, the quarter-round function and the initial-state builder.
package chacha20_pkg;

  localparam logic [31:0] Sigma0 = 32'h61707865;
  localparam logic [31:0] Sigma1 = 32'h3320646e;
  localparam logic [31:0] Sigma2 = 32'h79622d32;
  localparam logic [31:0] Sigma3 = 32'h6b206574;

  localparam int unsigned IdxKey     = 4;
  localparam int unsigned IdxCounter = 12;
  localparam int unsigned IdxNonce   = 13;

  // Word i of the state lives at bits [32i+31:32i].
  typedef logic [15:0][31:0] state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
  } qr_word_t;

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} fsm_e;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic qr_word_t quarter_round(input qr_word_t q);
    qr_word_t r;
    r   = q;
    r.a = r.a + r.b;
    r.d = rotl(r.d ^ r.a, 16);
    r.c = r.c + r.d;
    r.b = rotl(r.b ^ r.c, 12);
    r.a = r.a + r.b;
    r.d = rotl(r.d ^ r.a, 8);
    r.c = r.c + r.d;
    r.b = rotl(r.b ^ r.c, 7);
    return r;
  endfunction

  function automatic state_t init_state(input logic [255:0] key, input logic [95:0] nonce,
                                        input logic [31:0] counter);
    state_t s;
    s[0] = Sigma0;
    s[1] = Sigma1;
    s[2] = Sigma2;
    s[3] = Sigma3;
    for (int k = 0; k < 8; k++) s[IdxKey + k] = key[32*k +: 32];
    s[IdxCounter] = counter;
    for (int k = 0; k < 3; k++) s[IdxNonce + k] = nonce[32*k +: 32];
    return s;
  endfunction

endpackage

// File: rtl/chacha20_round_sel.sv
// Column/diagonal lane permutation: gathers the four QR operand sets from the working state
// and scatters the QR results back into their original word positions.
module chacha20_round_sel
  import chacha20_pkg::*;
(
  input  logic               diag_i,
  input  state_t             state_i,
  output qr_word_t [3:0]     qr_in_o,
  input  qr_word_t [3:0]     qr_out_i,
  output state_t             state_o
);

  // Row r of lane j: column picks word 4r+j, diagonal picks word 4r+((j+r) mod 4).
  function automatic logic [3:0] lane_idx(input logic diag, input logic [1:0] row,
                                          input logic [1:0] j);
    return {row, diag ? 2'(row + j) : j};
  endfunction

  always_comb begin
    qr_in_o = '0;
    state_o = state_i;
    for (int j = 0; j < 4; j++) begin
      qr_in_o[j].a = state_i[lane_idx(diag_i, 2'd0, 2'(j))];
      qr_in_o[j].b = state_i[lane_idx(diag_i, 2'd1, 2'(j))];
      qr_in_o[j].c = state_i[lane_idx(diag_i, 2'd2, 2'(j))];
      qr_in_o[j].d = state_i[lane_idx(diag_i, 2'd3, 2'(j))];
      state_o[lane_idx(diag_i, 2'd0, 2'(j))] = qr_out_i[j].a;
      state_o[lane_idx(diag_i, 2'd1, 2'(j))] = qr_out_i[j].b;
      state_o[lane_idx(diag_i, 2'd2, 2'(j))] = qr_out_i[j].c;
      state_o[lane_idx(diag_i, 2'd3, 2'(j))] = qr_out_i[j].d;
    end
  end

endmodule

// File: rtl/chacha20_block.sv
// Iterative ChaCha20 block function: one column or diagonal round per cycle, then feed-forward.
// Define CHACHA_ZEROIZE_EN to clear working/init/keystream registers on the output handshake.
module chacha20_block
  import chacha20_pkg::*;
#(
  parameter int unsigned ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream,
  output logic         busy
);

  if ((ROUNDS % 2) != 0 || ROUNDS < 2) begin : g_rounds_check
    $error("chacha20_block: ROUNDS must be even and at least 2");
  end

  localparam int unsigned CntW = $clog2(ROUNDS + 1);
  localparam logic [CntW-1:0] LastRound = CntW'(ROUNDS - 1);

  fsm_e            state_q, state_d;
  logic [CntW-1:0] round_q;
  state_t          work_q, init_q, ks_q, work_next;
  qr_word_t [3:0]  qr_in, qr_out;

  chacha20_round_sel u_round_sel (
    .diag_i   (round_q[0]),
    .state_i  (work_q),
    .qr_in_o  (qr_in),
    .qr_out_i (qr_out),
    .state_o  (work_next)
  );

  for (genvar g = 0; g < 4; g++) begin : g_qr
    assign qr_out[g] = quarter_round(qr_in[g]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_valid) state_d = StRound;
      StRound: if (round_q == LastRound) state_d = StFinal;
      StFinal: state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    start_ready = (state_q == StIdle);
    busy        = (state_q == StRound) || (state_q == StFinal);
    out_valid   = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_q <= '0;
      work_q  <= '0;
      init_q  <= '0;
      ks_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_valid) begin
            init_q  <= init_state(key, nonce, counter);
            work_q  <= init_state(key, nonce, counter);
            round_q <= '0;
          end
        end
        StRound: begin
          work_q  <= work_next;
          round_q <= round_q + 1'b1;
        end
        StFinal: begin
          for (int i = 0; i < 16; i++) ks_q[i] <= work_q[i] + init_q[i];
        end
        StDone: begin
`ifdef CHACHA_ZEROIZE_EN
          if (out_ready) begin
            work_q <= '0;
            init_q <= '0;
            ks_q   <= '0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign keystream = ks_q;

endmodule

// File: tb/tb_chacha20_block.sv
// Directed, table-driven bench for chacha20_block against the RFC 8439 vector and a local model.
module tb_chacha20_block;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [255:0] key = '0;
  logic [95:0]  nonce = '0;
  logic [31:0]  counter = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [511:0] keystream;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chacha20_block dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key         (key),
    .nonce       (nonce),
    .counter     (counter),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .keystream   (keystream),
    .busy        (busy)
  );

  typedef struct {
    logic [255:0] key;
    logic [95:0]  nonce;
    logic [31:0]  ctr;
    logic [511:0] exp;
  } vec_t;

  vec_t         vecs[4];
  logic [31:0]  rfc_words[16];
  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;
  logic [511:0] rfc_ks;

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] rq(input logic [31:0] a_in, input logic [31:0] b_in,
                                      input logic [31:0] c_in, input logic [31:0] d_in);
    logic [31:0] a, b, c, d;
    a = a_in; b = b_in; c = c_in; d = d_in;
    a = a + b; d = rol(d ^ a, 16);
    c = c + d; b = rol(b ^ c, 12);
    a = a + b; d = rol(d ^ a, 8);
    c = c + d; b = rol(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Reference: 10 double rounds driven from an index table, then feed-forward addition.
  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] ctr);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [127:0] t;
    logic [511:0] res;
    int           q[8][4];
    q = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
          '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = ctr;
    for (int i = 0; i < 3; i++) s[13 + i] = n[32*i +: 32];
    x = s;
    for (int dr = 0; dr < 10; dr++) begin
      for (int m = 0; m < 8; m++) begin
        t = rq(x[q[m][0]], x[q[m][1]], x[q[m][2]], x[q[m][3]]);
        x[q[m][0]] = t[127:96];
        x[q[m][1]] = t[95:64];
        x[q[m][2]] = t[63:32];
        x[q[m][3]] = t[31:0];
      end
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [527:0] act, input logic [527:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge just after the accept edge.
  task automatic start_req(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    int t;
    t = 0;
    key = k; nonce = n; counter = c; start_valid = 1'b1;
    while (!start_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("start_ready_wait", start_ready, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    key = ~k; nonce = ~n; counter = ~c;
  endtask

  // Counts rising edges after the accept edge until the first edge that sees out_valid high.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_ack", {out_valid, start_ready, busy}, 3'b010);
  endtask

  int           lat;
  int           n_acc, n_out;
  int           acc_cyc[2];
  logic [511:0] got[2];
  logic         acc_now, out_now;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rfc_words = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                  32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                  32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                  32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
    for (int i = 0; i < 16; i++) rfc_ks[32*i +: 32] = rfc_words[i];
    for (int k = 0; k < 8; k++)
      rfc_key[32*k +: 32] = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    vecs[0] = '{key: rfc_key, nonce: rfc_nonce, ctr: 32'h1, exp: rfc_ks};
    vecs[1] = '{key: rfc_key, nonce: rfc_nonce, ctr: 32'h2,
                exp: ref_block(rfc_key, rfc_nonce, 32'h2)};
    vecs[2] = '{key: '0, nonce: '0, ctr: 32'hffffffff, exp: ref_block('0, '0, 32'hffffffff)};
    vecs[3] = '{key: 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_13579bdf_2468ace0_fedcba98_76543210,
                nonce: 96'hcafebabe_00000000_deadbeef, ctr: 32'h12345678, exp: '0};
    vecs[3].exp = ref_block(vecs[3].key, vecs[3].nonce, vecs[3].ctr);

    // Reset state
    #2;
    check("reset_ctrl", {out_valid, start_ready, busy}, 3'b010);
    check("reset_keystream", keystream, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven blocks
    for (int v = 0; v < 4; v++) begin
      start_req(vecs[v].key, vecs[v].nonce, vecs[v].ctr);
      check($sformatf("running_%0d", v), {busy, start_ready, out_valid}, 3'b100);
      wait_valid(lat);
      check($sformatf("latency_%0d", v), lat, 22);
      check($sformatf("keystream_%0d", v), keystream, vecs[v].exp);
      take_output();
    end
`ifdef CHACHA_ZEROIZE_EN
    check("post_ack_keystream", keystream, '0);
`else
    check("post_ack_keystream", keystream, vecs[3].exp);
`endif

    // Backpressure: hold out_ready low, pulse start_valid with junk
    start_req(rfc_key, rfc_nonce, 32'h1);
    wait_valid(lat);
    check("bp_latency", lat, 22);
    for (int c = 0; c < 50; c++) begin
      start_valid = c[0];
      counter = c;
      check("bp_hold", {out_valid, start_ready, keystream}, {2'b10, rfc_ks});
      @(negedge clk);
    end
    start_valid = 1'b0;
    take_output();
    @(negedge clk);
    check("bp_no_stray_accept", {busy, start_ready}, 2'b01);

    // Back-to-back with out_ready tied high
    out_ready = 1'b1;
    key = rfc_key; nonce = rfc_nonce; counter = 32'h1; start_valid = 1'b1;
    n_acc = 0; n_out = 0;
    for (int c = 0; c < 100 && n_out < 2; c++) begin
      acc_now = start_valid && start_ready;
      out_now = out_valid && out_ready;
      if (acc_now) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end
      if (out_now) begin
        got[n_out] = keystream;
        n_out++;
      end
      @(negedge clk);
      if (acc_now) begin
        counter = 32'h2;
        if (n_acc == 2) start_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    start_valid = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_outputs", n_out, 2);
    check("b2b_gap", acc_cyc[1] - acc_cyc[0], 23);
    check("b2b_block1", got[0], rfc_ks);
    check("b2b_block2", got[1], vecs[1].exp);

    // Reset in the middle of the round phase
    start_req(rfc_key, rfc_nonce, 32'h1);
    repeat (6) @(negedge clk);
    check("mid_round_busy", {busy, out_valid}, 2'b10);
    rst_n = 1'b0;
    #1;
    check("mid_reset_ctrl", {out_valid, busy, start_ready}, 3'b001);
    check("mid_reset_keystream", keystream, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_req(rfc_key, rfc_nonce, 32'h1);
    wait_valid(lat);
    check("post_reset_latency", lat, 22);
    check("post_reset_keystream", keystream, rfc_ks);
    take_output();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
